// File: rtl/load_store_unit.sv
// Load/store unit: turns one LB/LH/LW/LBU/LHU/SB/SH/SW per request into a
// single word-aligned data-memory transaction over the req/ready interface.
// It handles byte-lane steering, load extension, misalignment and timeout.
module load_store_unit #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_valid,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] store_data,
  output logic        stall,
  output logic        done,
  output logic [31:0] load_data,
  output logic        exc_valid,
  output logic [1:0]  exc_cause,
  output logic [31:0] exc_addr,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_byte_enable,
  output logic        dmem_we,
  output logic        dmem_req,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_ready
);

  typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_RESP, S_ERR} state_t;

  // Terminal WAIT count: the last WAIT cycle is the one where cnt hits this.
  localparam logic [7:0] LAST_WAIT = 8'(TIMEOUT_CYCLES - 1);

  state_t      state;
  logic [7:0]  cnt;
  logic        is_load;
  logic [1:0]  size_q;
  logic        uns_q;
  logic [1:0]  off_q;
  logic [31:0] addr_q;

  logic        accept;
  logic [1:0]  size;
  logic [1:0]  off;
  logic        misaligned;
  logic [3:0]  be_n;
  logic [31:0] wdata_n;
  logic [31:0] shifted;
  logic [31:0] ext_data;

  assign accept     = mem_valid & (mem_read | mem_write);
  assign size       = funct3[1:0];
  assign off        = addr[1:0];
  // Half needs an even offset; word (size 2 or 3) needs offset 0.
  assign misaligned = ((size == 2'b01) & off[0]) | (size[1] & (off != 2'b00));

  assign stall = mem_valid & ~done & ~exc_valid;

  // Lane steering for the incoming request: byte enables and replicated data.
  always_comb begin
    be_n    = 4'b1111;
    wdata_n = store_data;
    case (size)
      2'b00: begin
        be_n    = 4'b0001 << off;
        wdata_n = {4{store_data[7:0]}};
      end
      2'b01: begin
        be_n    = 4'b0011 << off;
        wdata_n = {2{store_data[15:0]}};
      end
      default: ;
    endcase
  end

  // Right-align the addressed bytes of the read word and extend to 32 bits.
  always_comb begin
    shifted  = dmem_rdata >> {off_q, 3'b000};
    ext_data = shifted;
    case (size_q)
      2'b00: ext_data = uns_q ? {24'b0, shifted[7:0]}  : {{24{shifted[7]}}, shifted[7:0]};
      2'b01: ext_data = uns_q ? {16'b0, shifted[15:0]} : {{16{shifted[15]}}, shifted[15:0]};
      default: ;
    endcase
  end

  // Transaction FSM with all interface outputs registered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= S_IDLE;
      cnt              <= '0;
      is_load          <= 1'b0;
      size_q           <= '0;
      uns_q            <= 1'b0;
      off_q            <= '0;
      addr_q           <= '0;
      done             <= 1'b0;
      load_data        <= '0;
      exc_valid        <= 1'b0;
      exc_cause        <= '0;
      exc_addr         <= '0;
      dmem_addr        <= '0;
      dmem_wdata       <= '0;
      dmem_byte_enable <= '0;
      dmem_we          <= 1'b0;
      dmem_req         <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          cnt <= '0;
          if (accept) begin
            // A simultaneous read and write is treated as a load.
            is_load <= mem_read;
            size_q  <= size;
            uns_q   <= funct3[2];
            off_q   <= off;
            addr_q  <= addr;
            if (misaligned) begin
              state     <= S_ERR;
              exc_valid <= 1'b1;
              exc_cause <= mem_read ? 2'd0 : 2'd1;
              exc_addr  <= addr;
            end else begin
              state            <= S_REQ;
              dmem_req         <= 1'b1;
              dmem_addr        <= {addr[31:2], 2'b00};
              dmem_we          <= ~mem_read;
              dmem_byte_enable <= be_n;
              dmem_wdata       <= wdata_n;
            end
          end
        end
        S_REQ: begin
          // Request is strictly one cycle; memory starts an access per pulse.
          dmem_req <= 1'b0;
          cnt      <= '0;
          state    <= S_WAIT;
        end
        S_WAIT: begin
          cnt <= cnt + 8'd1;
          if (dmem_ready) begin
            state     <= S_RESP;
            done      <= 1'b1;
            load_data <= is_load ? ext_data : 32'd0;
          end else if (cnt == LAST_WAIT) begin
            state     <= S_ERR;
            exc_valid <= 1'b1;
            exc_cause <= is_load ? 2'd2 : 2'd3;
            exc_addr  <= addr_q;
          end
        end
        S_RESP: begin
          done  <= 1'b0;
          state <= S_IDLE;
        end
        S_ERR: begin
          exc_valid <= 1'b0;
          state     <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a small byte-lane memory model
// whose ready arrives two cycles after the request pulse.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_valid, mem_read, mem_write;
  logic [2:0]  funct3;
  logic [31:0] addr, store_data;
  logic        stall, done, exc_valid, dmem_we, dmem_req;
  logic [31:0] load_data, exc_addr, dmem_addr, dmem_wdata;
  logic [1:0]  exc_cause;
  logic [3:0]  dmem_byte_enable;
  logic [31:0] dmem_rdata = '0;
  logic        dmem_ready = 1'b0;

  load_store_unit #(.TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .rst(rst), .mem_valid(mem_valid), .mem_read(mem_read),
    .mem_write(mem_write), .funct3(funct3), .addr(addr), .store_data(store_data),
    .stall(stall), .done(done), .load_data(load_data), .exc_valid(exc_valid),
    .exc_cause(exc_cause), .exc_addr(exc_addr), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_byte_enable(dmem_byte_enable), .dmem_we(dmem_we),
    .dmem_req(dmem_req), .dmem_rdata(dmem_rdata), .dmem_ready(dmem_ready)
  );

  always #5 clk = ~clk;

  // Memory model: not reset by rst, so an in-flight access still answers.
  logic [31:0] mem [0:255];
  logic        mem_on = 1'b1;
  logic        req_d = 1'b0;
  always_ff @(posedge clk) begin
    req_d      <= dmem_req & mem_on;
    dmem_ready <= req_d;
    if (req_d) begin
      dmem_rdata <= mem[dmem_addr[9:2]];
      if (dmem_we)
        for (int b = 0; b < 4; b++)
          if (dmem_byte_enable[b]) mem[dmem_addr[9:2]][8*b +: 8] <= dmem_wdata[8*b +: 8];
    end
  end

  int passed = 0;
  int total  = 0;

  int          r_lat, r_req;
  logic        r_done, r_exc, r_we, r_stall;
  logic [3:0]  r_be;
  logic [1:0]  r_cause;
  logic [31:0] r_addr, r_wdata, r_ld, r_eaddr;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, " done"},  32'(done), 0);
    chk({tag, " ld"},    load_data, 0);
    chk({tag, " exc"},   32'(exc_valid), 0);
    chk({tag, " cause"}, 32'(exc_cause), 0);
    chk({tag, " eaddr"}, exc_addr, 0);
    chk({tag, " daddr"}, dmem_addr, 0);
    chk({tag, " wdata"}, dmem_wdata, 0);
    chk({tag, " be"},    32'(dmem_byte_enable), 0);
    chk({tag, " we"},    32'(dmem_we), 0);
    chk({tag, " req"},   32'(dmem_req), 0);
  endtask

  // Present one request at the current negedge and follow it to done/exc.
  // r_lat counts negedges after the accept edge (1 = first cycle after accept).
  task automatic issue(input logic rd, input logic wr, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] sd);
    mem_valid = 1'b1; mem_read = rd; mem_write = wr; funct3 = f3; addr = a; store_data = sd;
    r_lat = 99; r_req = 0; r_done = 0; r_exc = 0; r_we = 0; r_stall = 1'b1;
    r_be = '0; r_cause = '0; r_addr = '0; r_wdata = '0; r_ld = '0; r_eaddr = '0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (dmem_req) begin
        r_req++; r_be = dmem_byte_enable; r_we = dmem_we; r_addr = dmem_addr; r_wdata = dmem_wdata;
      end
      if (done || exc_valid) begin
        r_lat = k; r_done = done; r_exc = exc_valid; r_ld = load_data;
        r_cause = exc_cause; r_eaddr = exc_addr;
        if (stall) r_stall = 1'b0;
        break;
      end
      if (!stall) r_stall = 1'b0;
    end
    mem_valid = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
  endtask

  task automatic chk_ok(input string tag, input int lat, input logic [31:0] ld);
    chk({tag, " lat"},   32'(r_lat), 32'(lat));
    chk({tag, " done"},  32'(r_done), 1);
    chk({tag, " nreq"},  32'(r_req), 1);
    chk({tag, " ld"},    r_ld, ld);
    chk({tag, " stall"}, 32'(r_stall), 1);
  endtask

  task automatic chk_exc(input string tag, input int lat, input int nreq,
                         input logic [1:0] cause, input logic [31:0] ea);
    chk({tag, " lat"},   32'(r_lat), 32'(lat));
    chk({tag, " exc"},   32'(r_exc), 1);
    chk({tag, " done"},  32'(r_done), 0);
    chk({tag, " nreq"},  32'(r_req), 32'(nreq));
    chk({tag, " cause"}, 32'(r_cause), 32'(cause));
    chk({tag, " eaddr"}, r_eaddr, ea);
    chk({tag, " stall"}, 32'(r_stall), 1);
  endtask

  initial begin
    rst = 1'b1; mem_valid = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
    funct3 = '0; addr = '0; store_data = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_zero("reset");
    chk("reset stall", 32'(stall), 0);
    rst = 1'b0;
    @(negedge clk);

    // SW then LW of a full word
    issue(1'b0, 1'b1, 3'b010, 32'h100, 32'hDEADBEEF);
    chk_ok("sw", 4, 32'h0);
    chk("sw be", 32'(r_be), 32'hF);
    chk("sw we", 32'(r_we), 1);
    chk("sw addr", r_addr, 32'h100);
    chk("sw wdata", r_wdata, 32'hDEADBEEF);
    @(negedge clk);
    chk("sw done pulse", 32'(done), 0);
    issue(1'b1, 1'b0, 3'b010, 32'h100, 32'h0);
    chk_ok("lw", 4, 32'hDEADBEEF);
    chk("lw we", 32'(r_we), 0);
    chk("lw be", 32'(r_be), 32'hF);
    @(negedge clk);

    // SB to the top lane, then signed and unsigned byte loads
    issue(1'b0, 1'b1, 3'b000, 32'h103, 32'h12345680);
    chk_ok("sb", 4, 32'h0);
    chk("sb addr", r_addr, 32'h100);
    chk("sb be", 32'(r_be), 32'h8);
    chk("sb wdata", r_wdata, 32'h80808080);
    @(negedge clk);
    issue(1'b1, 1'b0, 3'b000, 32'h103, 32'h0);
    chk_ok("lb", 4, 32'hFFFFFF80);
    chk("lb be", 32'(r_be), 32'h8);
    @(negedge clk);
    issue(1'b1, 1'b0, 3'b100, 32'h103, 32'h0);
    chk_ok("lbu", 4, 32'h00000080);
    @(negedge clk);

    // SH to the upper half, then half loads and untouched low bytes
    issue(1'b0, 1'b1, 3'b001, 32'h102, 32'hABCD8001);
    chk_ok("sh", 4, 32'h0);
    chk("sh be", 32'(r_be), 32'hC);
    chk("sh wdata", r_wdata, 32'h80018001);
    @(negedge clk);
    issue(1'b1, 1'b0, 3'b001, 32'h102, 32'h0);
    chk_ok("lh", 4, 32'hFFFF8001);
    @(negedge clk);
    issue(1'b1, 1'b0, 3'b101, 32'h102, 32'h0);
    chk_ok("lhu", 4, 32'h00008001);
    @(negedge clk);
    issue(1'b1, 1'b0, 3'b100, 32'h100, 32'h0);
    chk_ok("lbu0", 4, 32'h000000EF);
    chk("lbu0 be", 32'(r_be), 32'h1);
    @(negedge clk);
    issue(1'b1, 1'b0, 3'b000, 32'h101, 32'h0);
    chk_ok("lb1", 4, 32'hFFFFFFBE);
    @(negedge clk);

    // Read and write both high: handled as a load
    issue(1'b1, 1'b1, 3'b010, 32'h100, 32'h55555555);
    chk_ok("rdwr", 4, 32'h8001BEEF);
    chk("rdwr we", 32'(r_we), 0);
    @(negedge clk);

    // Misaligned accesses: exception next cycle, no memory request
    issue(1'b1, 1'b0, 3'b010, 32'h101, 32'h0);
    chk_exc("lw mis", 1, 0, 2'd0, 32'h101);
    @(negedge clk);
    issue(1'b0, 1'b1, 3'b001, 32'h203, 32'h1234);
    chk_exc("sh mis", 1, 0, 2'd1, 32'h203);
    @(negedge clk);

    // Silent memory: 16 WAIT cycles then access fault; second request is
    // presented during ERR so it sees exactly one bubble before acceptance.
    mem_on = 1'b0;
    issue(1'b1, 1'b0, 3'b010, 32'h100, 32'h0);
    chk_exc("lw tmo", 18, 1, 2'd2, 32'h100);
    issue(1'b0, 1'b1, 3'b010, 32'h104, 32'hCAFEF00D);
    chk_exc("sw tmo", 19, 1, 2'd3, 32'h104);
    mem_on = 1'b1;
    @(negedge clk);

    // Reset during WAIT; the memory's late ready must be ignored
    mem_valid = 1'b1; mem_read = 1'b1; mem_write = 1'b0; funct3 = 3'b010; addr = 32'h100;
    @(negedge clk);
    chk("rst req", 32'(dmem_req), 1);
    @(negedge clk);
    rst = 1'b1; mem_valid = 1'b0; mem_read = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    chk_zero("midrst");
    @(negedge clk);
    chk("midrst done1", 32'(done), 0);
    chk("midrst req1", 32'(dmem_req), 0);
    @(negedge clk);
    chk("midrst done2", 32'(done), 0);
    issue(1'b1, 1'b0, 3'b010, 32'h100, 32'h0);
    chk_ok("lw post", 4, 32'h8001BEEF);
    @(negedge clk);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Initiator side of the data-memory req/ready interface. It sits between the CPU execute/memory stage and data_memory.
- Turns one load or store per request (LB/LH/LW/LBU/LHU/SB/SH/SW) into a single word-aligned memory transaction.
- Generates byte enables and lane-replicated write data, extracts and sign/zero-extends load data, detects misalignment, and applies a response timeout.

Parameters:
TIMEOUT_CYCLES, 16, max WAIT-state cycles before an access fault (1..255).

Ports:
clk  input  1  clock, all logic on rising edge
rst  input  1  synchronous active-high reset
mem_valid  input  1  pipeline request; held stable with all operands until done or exc_valid
mem_read  input  1  load request
mem_write  input  1  store request
funct3  input  3  [1:0] size (0=byte, 1=half, 2/3=word), [2] unsigned load
addr  input  32  byte address
store_data  input  32  store value (low bits used for SB/SH)
stall  output  1  mem_valid & ~done & ~exc_valid (combinational)
done  output  1  one-cycle completion pulse
load_data  output  32  extended load result, valid while done=1
exc_valid  output  1  one-cycle exception pulse
exc_cause  output  2  0 load misaligned, 1 store misaligned, 2 load access fault, 3 store access fault
exc_addr  output  32  faulting byte address
dmem_addr  output  32  {addr[31:2],2'b00}
dmem_wdata  output  32  lane-aligned write data
dmem_byte_enable  output  4  byte lanes
dmem_we  output  1  write strobe
dmem_req  output  1  single-cycle request
dmem_rdata  input  32  read word from memory
dmem_ready  input  1  one-cycle completion from memory

Behaviour:
- Reset (synchronous, rst=1 at clk edge):
  - State goes to IDLE.
  - All outputs go to 0: done, load_data, exc_valid, exc_cause, exc_addr, dmem_addr, dmem_wdata, dmem_byte_enable, dmem_we, dmem_req.
  - Timeout counter goes to 0.
- FSM states: IDLE, REQ, WAIT, RESP, ERR.
- IDLE:
  - Accepts when mem_valid & (mem_read | mem_write). If both are high, the access is a load.
  - Latches op, funct3, addr, store_data, and the offset off = addr[1:0].
  - Misaligned (half with off[0]=1, word with off!=0): go to ERR with cause 0 or 1. No dmem_req is issued.
  - Otherwise go to REQ.
- REQ:
  - Drives dmem_req=1 for exactly one cycle, then goes to WAIT.
  - Must never hold req high for two cycles; memory would start a second access.
  - dmem_addr, dmem_we, dmem_byte_enable and dmem_wdata are registered and stay stable from REQ until RESP/ERR.
- Byte enables:
  - Byte: 4'b0001<<off.
  - Half: 4'b0011<<off.
  - Word: 4'b1111.
  - Loads drive the same pattern with dmem_we=0.
- Write data:
  - SB: store_data[7:0] replicated 4x.
  - SH: store_data[15:0] replicated 2x.
  - SW: store_data unchanged.
- WAIT:
  - Counter increments each cycle.
  - dmem_ready=1: capture the result and go to RESP.
  - Counter reaches TIMEOUT_CYCLES with no ready: go to ERR with cause 2 or 3.
- RESP:
  - done=1 for one cycle, then IDLE.
  - For loads, load_data = (dmem_rdata >> 8*off), zero- or sign-extended from bit 7 (byte) or bit 15 (half).
  - For stores, load_data = 0.
- ERR:
  - exc_valid=1 for one cycle with exc_cause and exc_addr = latched addr, then IDLE.
- Latency: valid accepted in IDLE at cycle T, done at T+3+MEM_LATENCY (4 cycles for MEM_LATENCY=1). Misaligned access: exc_valid at T+1.
- Back-to-back: no new request is accepted during RESP or ERR. A new request can be accepted the cycle after (IDLE), giving at most one idle bubble.
- dmem_ready seen in IDLE, REQ, RESP or ERR is ignored.
- Reset mid-operation: the LSU returns to IDLE. A late dmem_ready from the memory's in-flight access is ignored. A timeout fault is fatal to the program; stale memory responses after a fault are not this block's responsibility.

Test Plan:
- SW 0xDEADBEEF @0x100, then LW @0x100 -> store: dmem_req one cycle, be=1111, we=1, done 4 cycles after accept; load: load_data=0xDEADBEEF.
- SB 0x80 @0x103 -> dmem_addr=0x100, be=1000, wdata=0x80808080; then LB @0x103 -> 0xFFFFFF80, LBU @0x103 -> 0x00000080.
- SH 0x8001 @0x102, then LH @0x102 -> 0xFFFF8001; LHU -> 0x00008001; bytes 0x100/0x101 unchanged.
- LW @0x101 and SH @0x203 -> exc_valid one cycle after accept, cause 0 / 1, exc_addr 0x101 / 0x203, dmem_req never asserted, stall drops with exc_valid.
- Memory model that never asserts ready -> exactly 16 WAIT cycles, then exc_valid with cause 2 (load) / 3 (store); LSU accepts a new request in the next cycle.
- rst pulsed during WAIT, then memory's delayed ready -> all outputs 0, ready ignored, no done; next LW completes normally.
